// File: rtl/mnist_check_pkg.sv
// ---------------------------------------------------------------------------
// mnist_check_pkg
// Shared definitions for the MNIST result checker slice:
//   state_e    - checker run state (IDLE, RUN, PASS, FAIL)
//   LABEL_W    - width of a class index / expected label
//   countWidth - width needed to hold a count from 0 up to maxCount
// ---------------------------------------------------------------------------
package mnist_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    localparam int LABEL_W = 4;

    // A count that can reach maxCount needs clog2(maxCount+1) bits; a
    // degenerate maxCount still gets one bit so port widths stay legal.
    function automatic int countWidth(input int maxCount);
        return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/mnist_result_checker_label_counter.sv
// ---------------------------------------------------------------------------
// label_counter
// Modulo-PERIOD up-counter with synchronous clear and count enable. Used to
// generate the expected label sequence 0..PERIOD-1 and equally usable as a
// decimal digit counter for the seven-segment display.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset, count returns to 0
//   clear  - synchronous clear to 0 (takes priority over enable)
//   enable - advance by one, wrapping PERIOD-1 -> 0
//   count  - current count value
// ---------------------------------------------------------------------------
module label_counter #(
    parameter int PERIOD = 10,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step and wrap at the top of the period.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == W'(PERIOD - 1)) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mnist_result_checker.sv
// ---------------------------------------------------------------------------
// mnist_result_checker
// Scoreboard downstream of the MNIST core. Compares each predicted class
// against the expected label sequence 0..LABEL_PERIOD-1 (wrapping), keeps
// hit/miss statistics, records the first mismatch and drives pass/fail.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start              - pulse: clear statistics and begin a run
//   result_valid       - strobe: pred_index / pred_value hold a result
//   pred_index         - predicted class index
//   pred_value         - score of the predicted class
//   busy/done/pass/fail- run status (RUN / PASS or FAIL / PASS / FAIL)
//   expected           - label expected for the next result
//   image_count        - results consumed in this run
//   hit_count          - matching results
//   miss_count         - mismatching results
//   first_fail_image   - 0-based image number of the first mismatch
//   first_fail_pred    - predicted index of the first mismatch
//   last_index         - most recent consumed pred_index
//   last_value         - most recent consumed pred_value
// All outputs are registered.
// ---------------------------------------------------------------------------
module mnist_result_checker
    import mnist_check_pkg::*;
#(
    parameter  int IMAGE_COUNT  = 480,
    parameter  int LABEL_PERIOD = 10,
    parameter  int STOP_ON_FAIL = 1,
    localparam int CW           = countWidth(IMAGE_COUNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               result_valid,
    input  logic [LABEL_W-1:0] pred_index,
    input  logic [7:0]         pred_value,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [LABEL_W-1:0] expected,
    output logic [CW-1:0]      image_count,
    output logic [CW-1:0]      hit_count,
    output logic [CW-1:0]      miss_count,
    output logic [CW-1:0]      first_fail_image,
    output logic [LABEL_W-1:0] first_fail_pred,
    output logic [LABEL_W-1:0] last_index,
    output logic [7:0]         last_value
);

    state_e             state_q, state_d;
    logic               busy_q, done_q, pass_q, fail_q;
    logic [CW-1:0]      image_count_q, image_count_d;
    logic [CW-1:0]      hit_count_q, hit_count_d;
    logic [CW-1:0]      miss_count_q, miss_count_d;
    logic [CW-1:0]      first_fail_image_q, first_fail_image_d;
    logic [LABEL_W-1:0] first_fail_pred_q, first_fail_pred_d;
    logic [LABEL_W-1:0] last_index_q, last_index_d;
    logic [7:0]         last_value_q, last_value_d;
    logic [LABEL_W-1:0] expected_label;
    logic               consume;
    logic               is_hit;
    logic               is_last;

    // A strobe is only consumed while running; start in the same cycle
    // restarts the run and the result is dropped.
    assign consume = result_valid && !start && (state_q == RUN);
    assign is_hit  = (pred_index == expected_label);
    assign is_last = (image_count_q == CW'(IMAGE_COUNT - 1));

    label_counter #(
        .PERIOD (LABEL_PERIOD),
        .W      (LABEL_W)
    ) u_label_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (consume),
        .count  (expected_label)
    );

    // Next-state logic for the run FSM and all statistics. Start clears
    // everything and enters RUN from any state; a consumed result updates
    // the counters and decides whether the run has ended.
    always_comb begin
        state_d            = state_q;
        image_count_d      = image_count_q;
        hit_count_d        = hit_count_q;
        miss_count_d       = miss_count_q;
        first_fail_image_d = first_fail_image_q;
        first_fail_pred_d  = first_fail_pred_q;
        last_index_d       = last_index_q;
        last_value_d       = last_value_q;
        if (start) begin
            state_d            = RUN;
            image_count_d      = '0;
            hit_count_d        = '0;
            miss_count_d       = '0;
            first_fail_image_d = '0;
            first_fail_pred_d  = '0;
            last_index_d       = '0;
            last_value_d       = '0;
        end else if (consume) begin
            image_count_d = image_count_q + CW'(1);
            last_index_d  = pred_index;
            last_value_d  = pred_value;
            if (is_hit) begin
                hit_count_d = hit_count_q + CW'(1);
            end else begin
                miss_count_d = miss_count_q + CW'(1);
                if (miss_count_q == '0) begin
                    first_fail_image_d = image_count_q;
                    first_fail_pred_d  = pred_index;
                end
            end
            // A miss on the final image fails regardless of STOP_ON_FAIL.
            if (!is_hit && ((STOP_ON_FAIL != 0) || is_last)) begin
                state_d = FAIL;
            end else if (is_last) begin
                state_d = (miss_count_q == '0) ? PASS : FAIL;
            end
        end
    end

    // State and statistics registers. Status flags are registered from the
    // next state so they line up with the counters they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            fail_q             <= 1'b0;
            image_count_q      <= '0;
            hit_count_q        <= '0;
            miss_count_q       <= '0;
            first_fail_image_q <= '0;
            first_fail_pred_q  <= '0;
            last_index_q       <= '0;
            last_value_q       <= '0;
        end else begin
            state_q            <= state_d;
            busy_q             <= (state_d == RUN);
            done_q             <= (state_d == PASS) || (state_d == FAIL);
            pass_q             <= (state_d == PASS);
            fail_q             <= (state_d == FAIL);
            image_count_q      <= image_count_d;
            hit_count_q        <= hit_count_d;
            miss_count_q       <= miss_count_d;
            first_fail_image_q <= first_fail_image_d;
            first_fail_pred_q  <= first_fail_pred_d;
            last_index_q       <= last_index_d;
            last_value_q       <= last_value_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail             = fail_q;
    assign expected         = expected_label;
    assign image_count      = image_count_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;
    assign first_fail_image = first_fail_image_q;
    assign first_fail_pred  = first_fail_pred_q;
    assign last_index       = last_index_q;
    assign last_value       = last_value_q;

endmodule

// File: tb/tb_mnist_result_checker.sv
// ---------------------------------------------------------------------------
// tb_mnist_result_checker
// Drives two checker instances (stop-on-fail and run-to-end, 20 images each)
// with the same stimulus. A behavioural model predicts every output per
// cycle; predictions are queued when stimulus is driven and popped and
// compared once the DUT has registered the result.
// ---------------------------------------------------------------------------
module tb_mnist_result_checker;

    localparam int IMGS = 20;
    localparam int CW   = $clog2(IMGS + 1);

    typedef struct {
        int st;
        int exp;
        int img;
        int hit;
        int miss;
        int ffImg;
        int ffPred;
        int lastIdx;
        int lastVal;
    } model_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       resultValid = 1'b0;
    logic [3:0] predIndex = 4'd0;
    logic [7:0] predValue = 8'd0;

    logic          busyO[2];
    logic          doneO[2];
    logic          passO[2];
    logic          failO[2];
    logic [3:0]    expectedO[2];
    logic [CW-1:0] imgO[2];
    logic [CW-1:0] hitO[2];
    logic [CW-1:0] missO[2];
    logic [CW-1:0] ffImgO[2];
    logic [3:0]    ffPredO[2];
    logic [3:0]    lastIdxO[2];
    logic [7:0]    lastValO[2];

    model_t mdl[2];
    model_t expQ[$];
    int     checks = 0;
    int     errors = 0;

    // Instance 0 stops on the first miss, instance 1 runs all images.
    mnist_result_checker #(.IMAGE_COUNT(IMGS), .LABEL_PERIOD(10), .STOP_ON_FAIL(1)) dutStop (
        .clk(clk), .rst(rst), .start(start), .result_valid(resultValid),
        .pred_index(predIndex), .pred_value(predValue),
        .busy(busyO[0]), .done(doneO[0]), .pass(passO[0]), .fail(failO[0]),
        .expected(expectedO[0]), .image_count(imgO[0]), .hit_count(hitO[0]),
        .miss_count(missO[0]), .first_fail_image(ffImgO[0]),
        .first_fail_pred(ffPredO[0]), .last_index(lastIdxO[0]), .last_value(lastValO[0])
    );

    mnist_result_checker #(.IMAGE_COUNT(IMGS), .LABEL_PERIOD(10), .STOP_ON_FAIL(0)) dutRun (
        .clk(clk), .rst(rst), .start(start), .result_valid(resultValid),
        .pred_index(predIndex), .pred_value(predValue),
        .busy(busyO[1]), .done(doneO[1]), .pass(passO[1]), .fail(failO[1]),
        .expected(expectedO[1]), .image_count(imgO[1]), .hit_count(hitO[1]),
        .miss_count(missO[1]), .first_fail_image(ffImgO[1]),
        .first_fail_pred(ffPredO[1]), .last_index(lastIdxO[1]), .last_value(lastValO[1])
    );

    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, required);
        end
    endtask

    function automatic model_t zeroModel();
        model_t z;
        z = '{default: 0};
        return z;
    endfunction

    // Reference behaviour: state codes 0 IDLE, 1 RUN, 2 PASS, 3 FAIL.
    function automatic model_t modelStep(input model_t m, input bit stop, input bit st,
                                         input bit v, input int idx, input int val);
        model_t n;
        int old;
        n = m;
        if (st) begin
            n = zeroModel();
            n.st = 1;
        end else if (v && m.st == 1) begin
            old       = m.img;
            n.img     = old + 1;
            n.lastIdx = idx;
            n.lastVal = val;
            n.exp     = (m.exp + 1) % 10;
            if (idx == m.exp) begin
                n.hit = m.hit + 1;
            end else begin
                if (m.miss == 0) begin
                    n.ffImg  = old;
                    n.ffPred = idx;
                end
                n.miss = m.miss + 1;
            end
            if (idx != m.exp && stop) n.st = 3;
            else if (old == IMGS - 1) n.st = (n.miss == 0) ? 2 : 3;
        end
        return n;
    endfunction

    task automatic compareDut(input int d, input model_t m);
        string p;
        p = (d == 0) ? "stop" : "run";
        checkOutput({p, ".busy"},     int'(busyO[d]),     int'(m.st == 1));
        checkOutput({p, ".done"},     int'(doneO[d]),     int'(m.st >= 2));
        checkOutput({p, ".pass"},     int'(passO[d]),     int'(m.st == 2));
        checkOutput({p, ".fail"},     int'(failO[d]),     int'(m.st == 3));
        checkOutput({p, ".expected"}, int'(expectedO[d]), m.exp);
        checkOutput({p, ".image"},    int'(imgO[d]),      m.img);
        checkOutput({p, ".hit"},      int'(hitO[d]),      m.hit);
        checkOutput({p, ".miss"},     int'(missO[d]),     m.miss);
        checkOutput({p, ".ffImg"},    int'(ffImgO[d]),    m.ffImg);
        checkOutput({p, ".ffPred"},   int'(ffPredO[d]),   m.ffPred);
        checkOutput({p, ".lastIdx"},  int'(lastIdxO[d]),  m.lastIdx);
        checkOutput({p, ".lastVal"},  int'(lastValO[d]),  m.lastVal);
    endtask

    // One clock of stimulus: drive at negedge, predict, compare after posedge.
    task automatic applyStimulus(input bit st, input bit v, input int idx, input int val);
        model_t e;
        @(negedge clk);
        start       = st;
        resultValid = v;
        predIndex   = idx[3:0];
        predValue   = val[7:0];
        for (int d = 0; d < 2; d++) begin
            mdl[d] = modelStep(mdl[d], (d == 0), st, v, idx, val);
            expQ.push_back(mdl[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e = expQ.pop_front();
            compareDut(d, e);
        end
        start       = 1'b0;
        resultValid = 1'b0;
    endtask

    // Twenty labelled images, correct except at badA/badB, with a few gaps.
    task automatic runImages(input int badA, input int badB, input int badPred, input int extra);
        int idx;
        for (int i = 0; i < IMGS + extra; i++) begin
            idx = i % 10;
            if (i == badA || i == badB) idx = badPred;
            if (i % 6 == 5) applyStimulus(1'b0, 1'b0, 0, 0);
            applyStimulus(1'b0, 1'b1, idx, int'($urandom_range(0, 255)));
        end
    endtask

    task automatic resetNow();
        rst = 1'b1;
        #1;
        mdl[0] = zeroModel();
        mdl[1] = zeroModel();
        compareDut(0, mdl[0]);
        compareDut(1, mdl[1]);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        mdl[0] = zeroModel();
        mdl[1] = zeroModel();
        #3;
        compareDut(0, mdl[0]);
        compareDut(1, mdl[1]);
        @(negedge clk);
        rst = 1'b0;

        // Strobes in IDLE are ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, i + 4, 100 + i);

        // All-correct run, then strobes in PASS are held off.
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("plan.startBusy", int'(busyO[0]), 1);
        runImages(-1, -1, 0, 0);
        checkOutput("plan.pass", int'(passO[0]), 1);
        checkOutput("plan.hit20", int'(hitO[1]), 20);
        checkOutput("plan.miss0", int'(missO[1]), 0);
        checkOutput("plan.expWrap", int'(expectedO[0]), 0);
        applyStimulus(1'b0, 1'b1, 3, 33);
        applyStimulus(1'b0, 1'b1, 0, 44);

        // Start with a simultaneous strobe: start wins.
        applyStimulus(1'b1, 1'b1, 0, 99);
        checkOutput("plan.prioImg", int'(imgO[0]), 0);
        checkOutput("plan.prioBusy", int'(busyO[1]), 1);

        // Single mismatch at image 13 (expected 3, pred 7), extra strobes after.
        runImages(13, -1, 7, 3);
        checkOutput("plan.stopFail", int'(failO[0]), 1);
        checkOutput("plan.stopFfImg", int'(ffImgO[0]), 13);
        checkOutput("plan.stopFfPred", int'(ffPredO[0]), 7);
        checkOutput("plan.stopImg", int'(imgO[0]), 14);
        checkOutput("plan.runFail", int'(failO[1]), 1);

        // Mismatches at images 4 and 9.
        applyStimulus(1'b1, 1'b0, 0, 0);
        runImages(4, 9, 7, 0);
        checkOutput("plan.endFail", int'(failO[1]), 1);
        checkOutput("plan.endMiss", int'(missO[1]), 2);
        checkOutput("plan.endHit", int'(hitO[1]), 18);
        checkOutput("plan.endFfImg", int'(ffImgO[1]), 4);

        // Only the last image wrong: both settings fail.
        applyStimulus(1'b1, 1'b0, 0, 0);
        runImages(19, -1, 7, 0);
        checkOutput("plan.lastFailRun", int'(failO[1]), 1);
        checkOutput("plan.lastPassRun", int'(passO[1]), 0);

        // Reset mid-run after 7 results, then strobes stay ignored.
        applyStimulus(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, i, 10 + i);
        resetNow();
        applyStimulus(1'b0, 1'b1, 0, 77);
        checkOutput("plan.postRstBusy", int'(busyO[0]), 0);

        // Correct run, restart from PASS, second correct run.
        applyStimulus(1'b1, 1'b0, 0, 0);
        runImages(-1, -1, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("plan.restartImg", int'(imgO[0]), 0);
        checkOutput("plan.restartBusy", int'(busyO[0]), 1);
        runImages(-1, -1, 0, 0);
        checkOutput("plan.restartPass", int'(passO[1]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mnist_result_checker.md
# mnist_result_checker

Scoreboard stage directly downstream of the `tt_um_rejunity_lgn_mnist` core on the iCEBreaker board. It takes one classification result per streamed image: a predicted class index and that class's score value. It compares each prediction with the expected label of the test set, which cycles 0..9, and keeps hit/miss statistics. It records the first mismatch and drives the pass/fail indication used by the board LEDs and seven-segment display.

## Interface
- `IMAGE_COUNT`, 480: images per run; must be ≥ 1.
- `LABEL_PERIOD`, 10: expected label sequence is 0..LABEL_PERIOD-1, then wraps to 0.
- `STOP_ON_FAIL`, 1: 1 = enter FAIL on the first mismatch; 0 = run all images, then judge.
- `clk  in  1`: single clock, the same clock as the mnist core.
- `rst  in  1`: asynchronous, active-high reset.
- `start  in  1`: one-cycle pulse; clears all statistics and begins a run.
- `result_valid  in  1`: one-cycle strobe; `pred_index` and `pred_value` hold a valid result.
- `pred_index  in  4`: class index predicted by the core.
- `pred_value  in  8`: score of the predicted class.
- `busy  out  1`: high while in RUN.
- `done  out  1`: high in PASS or FAIL.
- `pass  out  1`: high in PASS.
- `fail  out  1`: high in FAIL.
- `expected  out  4`: label expected for the next result.
- `image_count  out  CW`: results consumed in this run; CW = $clog2(IMAGE_COUNT+1).
- `hit_count  out  CW`: number of matching results.
- `miss_count  out  CW`: number of mismatching results.
- `first_fail_image  out  CW`: image number (0-based) of the first mismatch.
- `first_fail_pred  out  4`: `pred_index` of the first mismatch.
- `last_index  out  4`: most recent consumed `pred_index`.
- `last_value  out  8`: most recent consumed `pred_value`.

## Operation
- **States:** IDLE, RUN, PASS, FAIL. Reset enters IDLE.
- **Reset values:** every output is 0. `first_fail_image` and `first_fail_pred` also reset to 0 and are meaningful only once `miss_count` > 0.
- **IDLE → RUN** on `start`.
- **`start` from any other state:** restarts the run. Counters, `expected`, the first-fail record and the last-result registers clear, and the state goes to RUN.
- **`start` and `result_valid` in the same cycle:** `start` wins and the result is discarded.
- **`result_valid` outside RUN:** ignored. No output changes.
- **`result_valid` in RUN:**
  - `image_count` += 1.
  - `last_index`/`last_value` load the inputs.
  - `expected` advances; it wraps LABEL_PERIOD-1 → 0.
  - If `pred_index == expected`: `hit_count` += 1.
  - Otherwise: `miss_count` += 1. If this is the first miss (`miss_count == 0` before the update), `first_fail_image` ← old `image_count` and `first_fail_pred` ← `pred_index`.
- **RUN → FAIL:** on a mismatch when `STOP_ON_FAIL == 1`.
- **End of run:** when the consumed result is number IMAGE_COUNT-1 (old `image_count` == IMAGE_COUNT-1), go to PASS if there are no misses including this result, else FAIL. A mismatch on the last image goes to FAIL under either setting.
- **PASS/FAIL:** hold all outputs until `start` or `rst`.
- **Arithmetic:** counters never exceed IMAGE_COUNT, so there is no wrap inside a run. At all times `hit_count + miss_count == image_count`.

## Timing
- All outputs are registered and reflect a `result_valid` one cycle after it is sampled. There is no combinational path from input to output.
- `result_valid` may be asserted on back-to-back cycles, and every strobe in RUN is consumed. There is no backpressure.
- `start` takes effect on the next edge: `busy` goes high and the counters read 0 one cycle after `start`.
- `rst` asserted mid-run clears everything asynchronously. After release, the block stays in IDLE until `start`.

## Structure
- Package `mnist_check_pkg`:
  - state enum: IDLE, RUN, PASS, FAIL
  - `LABEL_W` = 4
  - CW derivation helper
- Sub-module `label_counter`: modulo-LABEL_PERIOD up-counter with clear and enable. It produces `expected` and is reusable for the display's decimal digit counter.

## Test plan
- **All correct:** IMAGE_COUNT=20; start, then 20 strobes with `pred_index` 0..9,0..9 → one cycle after the 20th strobe: `pass`=1, `hit_count`=20, `miss_count`=0, `expected`=0.
- **Stop on fail:** STOP_ON_FAIL=1; mismatch at image 13 (expected 3, pred 7) → `fail`=1, `first_fail_image`=13, `first_fail_pred`=7, `image_count`=14; later strobes leave all outputs unchanged.
- **Run to end with misses:** STOP_ON_FAIL=0, IMAGE_COUNT=20; mismatches at images 4 and 9 → run completes, `fail`=1, `miss_count`=2, `hit_count`=18, `first_fail_image`=4.
- **Ignored strobes and priority:** strobes in IDLE → no change. `start` together with `result_valid` → `image_count`=0, `busy`=1 next cycle.
- **Reset mid-run:** assert `rst` after 7 results → all outputs 0 immediately; release `rst` and strobe → still IDLE, no change.
- **Restart:** `start` while in PASS → counters 0 and `busy`=1 next cycle; a fresh 20-image correct run → PASS again.
